// File: rtl/mesh_terminal_tx.sv
// mesh_terminal_tx: per-terminal injection stage in front of one mesh router port.
// Formats destination/mode/payload requests into mesh packets. Requests with an
// illegal destination are dropped and flagged. Legal packets are queued in a
// first-word-fall-through FIFO that the router drains via pndng/popin.
module mesh_terminal_tx #(
  parameter int ROWS       = 4,
  parameter int COLUMNS    = 4,
  parameter int PAKG_SIZE  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MY_ROW     = 0,
  parameter int MY_COL     = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [3:0]                      req_row_i,
  input  logic [3:0]                      req_col_i,
  input  logic                            req_mode_i,
  input  logic [PAKG_SIZE-18:0]           req_payload_i,
  output logic                            pndng_o,
  output logic [PAKG_SIZE-1:0]            data_out_o,
  input  logic                            popin_i,
  output logic                            err_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic [15:0]                     sent_cnt_o,
  output logic [15:0]                     drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0]    ROW_LAST = 4'(ROWS + 1);
  localparam logic [3:0]    COL_LAST = 4'(COLUMNS + 1);
  localparam logic [3:0]    ROW_MAX  = 4'(ROWS);
  localparam logic [3:0]    COL_MAX  = 4'(COLUMNS);
  localparam logic [3:0]    SELF_ROW = 4'(MY_ROW);
  localparam logic [3:0]    SELF_COL = 4'(MY_COL);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [PAKG_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [15:0]          sent_q, drop_q;
  logic                 err_q;

  logic                 full, empty;
  logic                 accept, dest_ok, push, pop;
  logic                 row_edge, col_edge, row_in, col_in, is_self;
  logic [PAKG_SIZE-1:0] pkt;

  // Destination legality, packet formatting and the push/pop decisions.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    row_edge = (req_row_i == 4'd0) || (req_row_i == ROW_LAST);
    col_edge = (req_col_i == 4'd0) || (req_col_i == COL_LAST);
    row_in   = (req_row_i != 4'd0) && (req_row_i <= ROW_MAX);
    col_in   = (req_col_i != 4'd0) && (req_col_i <= COL_MAX);
    is_self  = (req_row_i == SELF_ROW) && (req_col_i == SELF_COL);
    dest_ok  = ((row_edge && col_in) || (col_edge && row_in)) && !is_self;
    accept   = req_valid_i && !full;
    push     = accept && dest_ok;
    pop      = popin_i && !empty;
    pkt      = {8'h00, req_row_i, req_col_i, req_mode_i, req_payload_i};
  end

  // FIFO storage, pointers, occupancy, error pulse and saturating counters.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= pkt;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (sent_q != '1) sent_q <= sent_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      err_q <= accept && !dest_ok;
      if (accept && !dest_ok && (drop_q != '1)) drop_q <= drop_q + 16'd1;
    end
  end

  // Outputs are taken from registered state only.
  always_comb begin
    req_ready_o = !full;
    pndng_o     = !empty;
    data_out_o  = mem_q[rd_ptr_q];
    err_o       = err_q;
    count_o     = count_q;
    sent_cnt_o  = sent_q;
    drop_cnt_o  = drop_q;
  end

endmodule
